// File: rtl/forward_ctrl_pkg.sv
// rtl/forward_ctrl_pkg.sv - pipeline package: forwarding select codes and EX/MEM descriptor type
package forward_ctrl_pkg;

    localparam int DESC_AW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic               valid;
        logic [DESC_AW-1:0] rd;
        logic               reg_write;
        logic               mem_read;
    } desc_t;

    // r0 is hardwired, so a descriptor targeting it never produces a forwardable result
    function automatic logic is_writing(input desc_t d);
        return d.valid && d.reg_write && (d.rd != '0);
    endfunction

endpackage

// File: rtl/forward_ctrl_fwd_match.sv
// rtl/forward_ctrl_fwd_match.sv - per-operand forwarding select, younger producer first
module fwd_match
    import forward_ctrl_pkg::*;
(
    input  logic [DESC_AW-1:0] src,
    input  logic               use_src,
    input  desc_t              ex_d,
    input  desc_t              mem_d,
    output logic [1:0]         sel
);

    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (is_writing(ex_d) && (ex_d.rd == src)) begin
                sel = FWD_EXMEM;
            end else if (is_writing(mem_d) && (mem_d.rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// rtl/forward_ctrl.sv - forwarding and load-use hazard controller for the 5-stage pipeline
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int REG_AW = DESC_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    desc_t      ex_q;
    desc_t      mem_q;
    desc_t      id_desc;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       advance;

    fwd_match u_match_a (
        .src     (id_rs),
        .use_src (id_use_rs),
        .ex_d    (ex_q),
        .mem_d   (mem_q),
        .sel     (sel_a)
    );

    fwd_match u_match_b (
        .src     (id_rt),
        .use_src (id_use_rt),
        .ex_d    (ex_q),
        .mem_d   (mem_q),
        .sel     (sel_b)
    );

    // A load in EX cannot feed a consumer in ID; one bubble puts it in MEM
    always_comb begin
        stall = id_valid && !flush && is_writing(ex_q) && ex_q.mem_read &&
                ((id_use_rs && (id_rs == ex_q.rd)) || (id_use_rt && (id_rt == ex_q.rd)));
    end

    assign advance = id_valid && !stall && !flush;

    always_comb begin
        id_desc           = '0;
        id_desc.valid     = 1'b1;
        id_desc.rd        = id_rd;
        id_desc.reg_write = id_reg_write;
        id_desc.mem_read  = id_mem_read;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            mem_q <= ex_q;
            if (advance) begin
                ex_q  <= id_desc;
                fwd_a <= sel_a;
                fwd_b <= sel_b;
            end else begin
                ex_q  <= '0;
                fwd_a <= FWD_RF;
                fwd_b <= FWD_RF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline.
- Tracks the destination register, write-enable and load flag of the instructions in EX and MEM.
- Produces registered 2-bit operand selects for the two EX-stage operand muxes: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- Raises a stall request on load-use hazards.
- Sits between ID decode and the EX-stage operand muxes, and drives their `choice` inputs directly.

## Interface
- REG_AW, 5, register address width.
- CNT_W, 32, width of the stall performance counter.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs  in  REG_AW  source register A of the ID instruction.
- id_rt  in  REG_AW  source register B of the ID instruction.
- id_use_rs  in  1  the ID instruction reads rs.
- id_use_rt  in  1  the ID instruction reads rt.
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_reg_write  in  1  the ID instruction writes id_rd.
- id_mem_read  in  1  the ID instruction is a load.
- flush  in  1  kill the ID instruction (branch/jump redirect).
- fwd_a  out  2  operand A select for the instruction currently in EX.
- fwd_b  out  2  operand B select for the instruction currently in EX.
- stall  out  1  hold PC and IF/ID; a bubble is inserted into EX.
- stall_cnt  out  CNT_W  number of cycles with stall=1 since reset.

## Operation
- Internal pipeline of descriptors {valid, rd, reg_write, mem_read}: ex_q (instruction in EX) and mem_q (instruction in MEM).
- A descriptor is "writing" when valid=1, reg_write=1 and rd≠0.
- Combinational stall = id_valid & ~flush & ex_q is writing & ex_q.mem_read & ((id_use_rs & id_rs==ex_q.rd) | (id_use_rt & id_rt==ex_q.rd)).
- Advance, every rising edge: mem_q ← ex_q.
- ex_q loads the ID descriptor when id_valid & ~stall & ~flush; otherwise it loads a bubble (valid=0).
- When the ID instruction advances, compute next fwd_a from id_rs and id_use_rs:
  - 01 if ex_q is writing and ex_q.rd==id_rs. At the next edge ex_q moves to MEM, so its result is in EX/MEM.
  - else 10 if mem_q is writing and mem_q.rd==id_rs.
  - else 00.
- fwd_b uses the same rule with id_rt and id_use_rt.
- A bubble entering EX loads fwd_a=fwd_b=00.
- Priority: EX/MEM beats MEM/WB, because the younger producer wins.
- Register 0 is never forwarded.
- Encoding 11 is never produced.
- Load consumer after one stall: the load is in MEM when the consumer advances, so the consumer gets select 10.
- The register file is write-before-read, so no forwarding is needed from instructions older than WB.
- stall_cnt increments on every cycle with stall=1 and wraps at 2^CNT_W.

## Timing
- Reset (asynchronous, immediate):
  - ex_q.valid=0 and mem_q.valid=0.
  - fwd_a=00, fwd_b=00, stall_cnt=0.
  - stall=0, because ex_q is invalid.
- fwd_a/fwd_b are registered. They change only at a rising edge and are stable for the whole EX cycle of the instruction they belong to.
- stall is combinational from the ID inputs and ex_q, valid in the same cycle. The load-use stall lasts exactly one cycle, because the next edge inserts a bubble and ex_q.mem_read becomes 0.
- flush & stall in the same cycle: flush wins. stall=0, a bubble enters EX, and the counter does not increment.
- id_valid=0: a bubble enters EX and stall=0.
- Reset asserted mid-stall: stall drops immediately and all in-flight descriptors are discarded.
- Latency: decode inputs to select outputs is 1 edge. stall has zero latency.

## Structure
- Shared package (pipeline package):
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The descriptor struct {valid, rd, reg_write, mem_read}.
- One sub-module, fwd_match: combinational per-operand select.
  - Inputs: src register, use flag, ex_q and mem_q descriptors.
  - Output: a 2-bit select.
  - Instantiated twice, once for A and once for B.
- The top level holds ex_q, mem_q, the output registers, the stall logic and stall_cnt.

## Test plan
- add r3←r1,r2 followed by sub r5←r3,r4 → at sub's EX cycle fwd_a=01, fwd_b=00, with no stall.
- add r3; nop; or r6←r2,r3 → at or's EX cycle fwd_b=10 and fwd_a=00.
- lw r4←0(r1) followed by add r7←r4,r4:
  - stall=1 for exactly one cycle.
  - a bubble enters EX with selects 00.
  - at add's EX cycle fwd_a=fwd_b=10.
  - stall_cnt=1.
- add r0←r1,r2 followed by sub r5←r0,r0 → fwd_a=fwd_b=00.
- add r3; add r3; and r8←r3,r3 → the younger producer wins: fwd_a=fwd_b=01.
- lw r4 followed by add using r4, with flush=1 in the same cycle → stall=0, a bubble enters EX, and stall_cnt is unchanged.
- Assert rst during a load-use stall → stall=0 immediately, fwd_a=fwd_b=00, stall_cnt=0.
